mul_share_arbiter: RTL and testbench
====================================

// Module: mul_share_arbiter
// PURPOSE
//   Shares one pipelined signed multiplier (W x W -> 2W, LAT-cycle registered
//   latency, clk/rst_n/en interface) between NREQ requesters. Round-robin arbitration,
//   at most one operand pair issued per cycle. A tag pipeline routes each product
//   back to its requester. Sits between datapath clients and the multiplier instance.
// PARAMETERS
//   NREQ  4   number of requesters (2..8)
//   W     11  signed operand width
//   LAT   1   multiplier latency in cycles, issue to mul_p valid (1..4)
// PORTS
//   clk        in   1        clock, rising edge
//   rst_n      in   1        asynchronous active-low reset
//   en         in   1        arbitration enable; low = no new grants, in-flight ops drain
//   req_valid  in   NREQ     per-requester operand valid
//   req_ready  out  NREQ     one-hot grant; handshake = req_valid[i] & req_ready[i]
//   req_a      in   NREQ*W   operand A, requester i at [i*W +: W], signed
//   req_b      in   NREQ*W   operand B, same packing
//   rsp_valid  out  NREQ     one-hot product-valid pulse, 1 cycle
//   rsp_p      out  2W       signed product; meaningful only while |rsp_valid
//   busy       out  1        high while any op is in flight
//   mul_en     out  1        multiplier enable
//   mul_a      out  W        multiplier operand A
//   mul_b      out  W        multiplier operand B
//   mul_p      in   2W       multiplier product, LAT cycles after issue
// BEHAVIOUR
//   - Reset (async, rst_n=0): RR pointer=0, tag pipe cleared, mul_en=0, busy=0,
//     rsp_valid=0, req_ready=0. mul_a/mul_b=0. Released synchronously on clk.
//   - mul_en: register. 0 in reset, 1 from first clk edge after release. Never dropped
//     by en, so in-flight ops always drain.
//   - Grant (combinational): if en & mul_en & |req_valid, grant the first valid index
//     searching ptr, ptr+1, ... with wrap mod NREQ. Else req_ready=0.
//     req_ready never asserts to a requester whose req_valid is low.
//   - On handshake to i: mul_a/mul_b = req_a/req_b slice i (muxed same cycle);
//     ptr <= (i+1) mod NREQ. No handshake: ptr holds, mul_a/mul_b = 0.
//   - Tag pipe: LAT stages of {vld, idx}. Stage 0 loads {handshake, i} each clk.
//     When the last stage has vld, rsp_valid[idx]=1 and rsp_p=mul_p in that cycle.
//     Result appears exactly LAT cycles after the handshake edge. Order = issue order.
//   - Responses have no backpressure. Requesters must accept rsp_valid pulses.
//   - Throughput: 1 issue/cycle sustained. Issue and response in the same cycle are
//     legal and independent.
//   - busy = OR of all tag-pipe vld bits.
//   - FSM (2 bits): IDLE (no vld, en or not) -> RUN on handshake.
//     RUN -> DRAIN when en=0 and tags in flight.
//     DRAIN -> IDLE when pipe empties; DRAIN -> RUN if en returns.
//     RUN -> IDLE when pipe empties with no handshake.
//   - Width rule: product is 2W bits. (-2^(W-1))^2 = +2^(2W-2) does not fit 2W-1 bits.
//   - Reset mid-operation: all in-flight tags are discarded. No rsp_valid pulse occurs
//     for them after release.
//   - Single requester: granted every cycle it is valid (ptr wraps back to it).
// CONFIGURATION
//   MUL_ARB_PERF_CNT_EN defined: adds outputs perf_issue_cnt[31:0] and
//     perf_stall_cnt[31:0], both reset to 0 and saturating at 32'hFFFFFFFF.
//     issue increments on each handshake.
//     stall increments each cycle with a valid requester not granted (one count/cycle).
//   Not defined: these ports and counters do not exist. All other behaviour is identical.
// TESTING
//   1 Reset: rst_n=0 with req_valid=4'hF -> req_ready=0, rsp_valid=0, busy=0,
//     mul_en=0. First edge after release -> mul_en=1.
//   2 Corner product: req0 A=-1024 B=-1024, LAT=1 -> next cycle rsp_valid=4'b0001,
//     rsp_p=+1048576. Also A=-1024 B=1023 -> rsp_p=-1047552.
//   3 RR fairness: req_valid=4'hF held 8 cycles, A=i+1, B=-3 -> grants 0,1,2,3,0,1,2,3;
//     rsp_p sequence -3,-6,-9,-12 repeated, each on the matching rsp_valid bit.
//   4 en drop: grants flowing, en=0 -> req_ready=0 next cycle. In-flight results still
//     arrive; busy falls LAT cycles later. FSM goes RUN->DRAIN->IDLE.
//   5 Reset mid-op: LAT=3, two ops issued, rst_n pulsed low -> no rsp_valid after
//     release. ptr=0, so req0 is granted first.
//   6 Perf (macro on): req_valid=4'hF for 8 cycles -> perf_issue_cnt=8,
//     perf_stall_cnt=8. Force saturation -> counters stay at 32'hFFFFFFFF.

Source files
------------

// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one pipelined signed multiplier among NREQ clients.
// Optional perf counters are enabled by defining MUL_ARB_PERF_CNT_EN.
module mul_share_arbiter #(
    parameter int NREQ = 4,
    parameter int W    = 11,
    parameter int LAT  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [2*W-1:0]    rsp_p,
    output logic              busy,
    output logic              mul_en,
    output logic [W-1:0]      mul_a,
    output logic [W-1:0]      mul_b,
    input  logic [2*W-1:0]    mul_p
`ifdef MUL_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       perf_issue_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_ptr;
    logic            r_mul_en;
    logic [LAT-1:0]  r_vld;
    logic [PW-1:0]   r_idx [LAT];

    logic            w_hs;
    logic [PW-1:0]   w_gidx;
    logic [NREQ-1:0] w_gnt;
    logic [PW:0]     w_sum;
    logic [PW-1:0]   w_j;
    logic            w_in_flight;

    // First valid requester at or after the pointer, wrapping mod NREQ.
    always_comb begin
        w_hs   = 1'b0;
        w_gidx = '0;
        w_gnt  = '0;
        w_sum  = '0;
        w_j    = '0;
        if (en && r_mul_en) begin
            for (int k = 0; k < NREQ; k++) begin
                w_sum = {1'b0, r_ptr} + (PW+1)'(k);
                if (w_sum >= (PW+1)'(NREQ)) begin
                    w_sum = w_sum - (PW+1)'(NREQ);
                end
                w_j = w_sum[PW-1:0];
                if (!w_hs && req_valid[w_j]) begin
                    w_hs   = 1'b1;
                    w_gidx = w_j;
                end
            end
        end
        if (w_hs) begin
            w_gnt[w_gidx] = 1'b1;
        end
    end

    assign req_ready = w_gnt;
    assign mul_en    = r_mul_en;
    assign mul_a     = w_hs ? req_a[int'(w_gidx)*W +: W] : '0;
    assign mul_b     = w_hs ? req_b[int'(w_gidx)*W +: W] : '0;

    // Tags that will still be in the pipe after the coming edge.
    always_comb begin
        w_in_flight = w_hs;
        for (int k = 0; k < LAT-1; k++) begin
            w_in_flight = w_in_flight | r_vld[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr    <= '0;
            r_mul_en <= 1'b0;
            r_state  <= S_IDLE;
            r_vld    <= '0;
            for (int k = 0; k < LAT; k++) begin
                r_idx[k] <= '0;
            end
        end else begin
            r_mul_en <= 1'b1;
            r_state  <= w_state_nxt;
            if (w_hs) begin
                r_ptr <= (w_gidx == PW'(NREQ-1)) ? '0
                                                 : w_gidx + 1'b1;
            end
            r_vld[0] <= w_hs;
            r_idx[0] <= w_gidx;
            for (int k = 1; k < LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_idx[k] <= r_idx[k-1];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_hs) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!w_in_flight) w_state_nxt = S_IDLE;
                else if (!en)     w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (!w_in_flight) w_state_nxt = S_IDLE;
                else if (en)      w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Non-IDLE tracks exactly the OR of the tag-pipe valid bits.
    assign busy = (r_state != S_IDLE);

    always_comb begin
        rsp_valid = '0;
        rsp_p     = '0;
        if (r_vld[LAT-1]) begin
            rsp_valid[r_idx[LAT-1]] = 1'b1;
            rsp_p                   = mul_p;
        end
    end

`ifdef MUL_ARB_PERF_CNT_EN
    logic [31:0] r_issue;
    logic [31:0] r_stall;
    logic        w_stall;

    assign w_stall = |(req_valid & ~w_gnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue <= '0;
            r_stall <= '0;
        end else begin
            if (w_hs && (r_issue != 32'hFFFF_FFFF)) begin
                r_issue <= r_issue + 32'd1;
            end
            if (w_stall && (r_stall != 32'hFFFF_FFFF)) begin
                r_stall <= r_stall + 32'd1;
            end
        end
    end

    assign perf_issue_cnt = r_issue;
    assign perf_stall_cnt = r_stall;
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Randomized bench for mul_share_arbiter against a queue-based model.
// Perf counters are checked when MUL_ARB_PERF_CNT_EN is defined.
module tb_mul_share_arbiter;

    localparam int NREQ = 4;
    localparam int W    = 11;
    localparam int LAT  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              en;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   rsp_valid;
    logic [2*W-1:0]    rsp_p;
    logic              busy;
    logic              mul_en;
    logic [W-1:0]      mul_a;
    logic [W-1:0]      mul_b;
    logic [2*W-1:0]    mul_p;
`ifdef MUL_ARB_PERF_CNT_EN
    logic [31:0]       perf_issue_cnt;
    logic [31:0]       perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    mul_share_arbiter #(
        .NREQ(NREQ),
        .W   (W),
        .LAT (LAT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_a    (req_a),
        .req_b    (req_b),
        .rsp_valid(rsp_valid),
        .rsp_p    (rsp_p),
        .busy     (busy),
        .mul_en   (mul_en),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_p    (mul_p)
`ifdef MUL_ARB_PERF_CNT_EN
        ,
        .perf_issue_cnt(perf_issue_cnt),
        .perf_stall_cnt(perf_stall_cnt)
`endif
    );

    // Pipelined multiplier stand-in
    logic [2*W-1:0] p_pipe [LAT];

    always_ff @(posedge clk) begin
        if (mul_en) begin
            p_pipe[0] <= (2*W)'($signed(mul_a)) * (2*W)'($signed(mul_b));
            for (int k = 1; k < LAT; k++) begin
                p_pipe[k] <= p_pipe[k-1];
            end
        end
    end

    assign mul_p = p_pipe[LAT-1];

    typedef struct {
        int     due;
        int     idx;
        longint p;
    } pend_t;

    pend_t  q[$];
    int     opa [NREQ];
    int     opb [NREQ];
    int     m_ptr;
    bit     m_mulen;
    longint m_issue;
    longint m_stall;
    int     cyc;
    int     n_chk;
    int     n_fail;

    task automatic chk(input string tag, input longint got,
                       input longint exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic cycle_chk();
        int              g;
        int              j;
        logic [NREQ-1:0] eg;
        logic [NREQ-1:0] erv;
        longint          ea;
        longint          eb;
        longint          ep;
        bit              st;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*W +: W] = W'(opa[i]);
            req_b[i*W +: W] = W'(opb[i]);
        end
        #1;
        g = -1;
        if (rst_n && en && m_mulen) begin
            for (int k = 0; k < NREQ; k++) begin
                j = (m_ptr + k) % NREQ;
                if (g < 0 && req_valid[j]) g = j;
            end
        end
        eg = '0;
        ea = 0;
        eb = 0;
        if (g >= 0) begin
            eg[g] = 1'b1;
            ea = opa[g];
            eb = opb[g];
        end
        erv = '0;
        ep  = 0;
        if (q.size() > 0 && q[0].due == cyc) begin
            erv[q[0].idx] = 1'b1;
            ep = q[0].p;
        end
        st = rst_n && ((req_valid & ~eg) != '0);
        chk("req_ready", longint'(req_ready), longint'(eg));
        chk("mul_a", longint'($signed(mul_a)), ea);
        chk("mul_b", longint'($signed(mul_b)), eb);
        chk("mul_en", longint'(mul_en), longint'(m_mulen));
        chk("rsp_valid", longint'(rsp_valid), longint'(erv));
        chk("busy", longint'(busy), longint'(q.size() > 0));
        if (erv != '0) begin
            chk("rsp_p", longint'($signed(rsp_p)), ep);
        end
`ifdef MUL_ARB_PERF_CNT_EN
        chk("perf_issue", longint'(perf_issue_cnt), m_issue);
        chk("perf_stall", longint'(perf_stall_cnt), m_stall);
`endif
        @(posedge clk);
        if (rst_n) begin
            if (q.size() > 0 && q[0].due == cyc) begin
                void'(q.pop_front());
            end
            if (g >= 0) begin
                q.push_back('{due: cyc + LAT, idx: g, p: ea * eb});
                m_ptr = (g + 1) % NREQ;
                m_issue++;
            end
            if (st) m_stall++;
            m_mulen = 1'b1;
        end
        cyc++;
        @(negedge clk);
    endtask

    task automatic rst_cycles(input int n);
        rst_n   = 1'b0;
        q.delete();
        m_ptr   = 0;
        m_mulen = 1'b0;
        m_issue = 0;
        m_stall = 0;
        repeat (n) cycle_chk();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        en        = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        cyc       = 0;
        n_chk     = 0;
        n_fail    = 0;
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = 0;
            opb[i] = 0;
        end
        @(negedge clk);

        req_valid = '1;
        rst_cycles(3);
        req_valid = '0;
        repeat (2) cycle_chk();

        req_valid = 4'b0001;
        opa[0] = -1024;
        opb[0] = -1024;
        cycle_chk();
        opb[0] = 1023;
        cycle_chk();
        req_valid = '0;
        repeat (LAT + 1) cycle_chk();

        for (int i = 0; i < NREQ; i++) begin
            opa[i] = i + 1;
            opb[i] = -3;
        end
        req_valid = '1;
        repeat (8) cycle_chk();
        req_valid = '0;
        repeat (LAT + 1) cycle_chk();

        req_valid = '1;
        repeat (4) cycle_chk();
        en = 1'b0;
        repeat (LAT + 2) cycle_chk();
        en = 1'b1;
        req_valid = '0;
        cycle_chk();

        req_valid = '1;
        repeat (2) cycle_chk();
        rst_cycles(2);
        repeat (LAT + 3) cycle_chk();

        req_valid = 4'b0100;
        repeat (4) cycle_chk();

        repeat (3000) begin
            req_valid = NREQ'($urandom);
            en = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < NREQ; i++) begin
                opa[i] = int'($urandom_range(0, 2047)) - 1024;
                opb[i] = int'($urandom_range(0, 2047)) - 1024;
            end
            if ($urandom_range(0, 199) == 0) begin
                rst_cycles(int'($urandom_range(1, 3)));
            end else begin
                cycle_chk();
            end
        end
        req_valid = '0;
        repeat (LAT + 2) cycle_chk();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
